conv1d_mac_engine: RTL and testbench

//  Parametrised successor CFU datapath for 1-D convolution: int8 input ring buffer x int8 kernel buffer, LANES MACs/cycle.

---
 rtl/conv1d_mac_engine.sv | 211 +++++++++++++++++++++
 tb/tb_conv1d_mac_engine.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1d_mac_engine.sv
`default_nettype none
// ============================================================================
// Module   : conv1d_mac_engine
// Purpose  : CFU datapath for int8 1-D convolution. Firmware fills an input
//            ring buffer and a kernel buffer, sets depth/offset/bias/start
//            column, starts the engine and polls status. The engine issues
//            LANES multiply-accumulates per cycle through a two-stage pipe
//            (lane-sum register, then accumulator add).
// Ports    : clk                 - clock
//            reset               - synchronous, active-high
//            en                  - cycle enable; 0 freezes everything
//            cmd[6:0]            - command code
//            inp0/inp1           - address / value operands
//            ret                 - registered response (cycle after cmd)
//            output_buffer_valid - constant 1
// Revision : 1.0 - initial release
// ============================================================================
module conv1d_mac_engine #(
  parameter int KERNEL_LENGTH      = 8,
  parameter int MAX_INPUT_CHANNELS = 128,
  parameter int LANES              = 8,
  parameter int INT32_SIZE         = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [6:0]            cmd,
  input  logic [INT32_SIZE-1:0] inp0,
  input  logic [INT32_SIZE-1:0] inp1,
  output logic [INT32_SIZE-1:0] ret,
  output logic                  output_buffer_valid
);

  localparam int BUFFERS_SIZE = KERNEL_LENGTH * MAX_INPUT_CHANNELS;
  localparam int ADDR_W       = (BUFFERS_SIZE > 1) ? $clog2(BUFFERS_SIZE) : 1;
  // Wide enough for base + kidx (< 2N) plus a trailing partial chunk.
  localparam int IDX_W        = $clog2(2 * BUFFERS_SIZE + 2 * LANES) + 1;
  localparam int DEPTH_W      = $clog2(MAX_INPUT_CHANNELS + 1);

  localparam logic [6:0] CMD_SIZE    = 7'd0;
  localparam logic [6:0] CMD_WR_IN   = 7'd1;
  localparam logic [6:0] CMD_WR_K    = 7'd2;
  localparam logic [6:0] CMD_OFFSET  = 7'd3;
  localparam logic [6:0] CMD_BIAS    = 7'd4;
  localparam logic [6:0] CMD_DEPTH   = 7'd5;
  localparam logic [6:0] CMD_START   = 7'd6;
  localparam logic [6:0] CMD_RD_ACC  = 7'd7;
  localparam logic [6:0] CMD_START_X = 7'd8;
  localparam logic [6:0] CMD_STATUS  = 7'd9;
  localparam logic [6:0] CMD_ABORT   = 7'd10;
  localparam logic [6:0] CMD_CYCLES  = 7'd11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [7:0]            r_in_buf [BUFFERS_SIZE];
  logic [7:0]            r_k_buf  [BUFFERS_SIZE];
  logic [INT32_SIZE-1:0] r_offset, r_bias, r_acc, r_cycles, r_s1_sum;
  logic [DEPTH_W-1:0]    r_depth;
  logic [IDX_W-1:0]      r_start_x, r_step, r_iss_step;
  logic                  r_err, r_aborted, r_done, r_iss_vld, r_s1_vld;

  logic [IDX_W-1:0]      w_n, w_base, w_steps, w_last_step;
  logic                  w_busy, w_start, w_abort, w_addr_ok, w_cfg_cmd;
  logic                  w_wr_in, w_wr_k, w_depth_ok;
  logic [INT32_SIZE-1:0] w_lane_sum;
  logic [INT32_SIZE-1:0] w_term [LANES];

  assign output_buffer_valid = 1'b1;

  assign w_n         = IDX_W'(KERNEL_LENGTH) * IDX_W'(r_depth);
  assign w_base      = r_start_x * IDX_W'(r_depth);
  assign w_steps     = (w_n + IDX_W'(LANES - 1)) / IDX_W'(LANES);
  // depth 0 never passes validation after reset; still issue one (masked) step.
  assign w_last_step = (w_steps == '0) ? '0 : w_steps - IDX_W'(1);

  // A final add may still be pending after the FSM returns to IDLE.
  assign w_busy     = (r_state != ST_IDLE) || r_s1_vld;
  assign w_start    = en && (cmd == CMD_START) && !w_busy;
  assign w_abort    = en && (cmd == CMD_ABORT) && (r_state != ST_IDLE);
  assign w_addr_ok  = inp0 < INT32_SIZE'(BUFFERS_SIZE);
  assign w_cfg_cmd  = (cmd == CMD_WR_IN) || (cmd == CMD_WR_K) || (cmd == CMD_OFFSET) ||
                      (cmd == CMD_BIAS) || (cmd == CMD_DEPTH) || (cmd == CMD_START_X);
  assign w_wr_in    = en && (cmd == CMD_WR_IN) && !w_busy && w_addr_ok;
  assign w_wr_k     = en && (cmd == CMD_WR_K) && !w_busy && w_addr_ok;
  assign w_depth_ok = (inp1 != '0) && (inp1 <= INT32_SIZE'(MAX_INPUT_CHANNELS));

  // Per-lane product for the issued step; kernel index past N contributes 0.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [IDX_W-1:0]             w_kidx, w_iraw, w_iidx;
    logic [7:0]                   w_kbyte, w_ibyte;
    logic signed [INT32_SIZE-1:0] w_kval, w_ival;

    assign w_kidx  = r_iss_step * IDX_W'(LANES) + IDX_W'(i);
    assign w_iraw  = w_base + w_kidx;
    assign w_iidx  = (w_iraw >= w_n) ? (w_iraw - w_n) : w_iraw;
    assign w_kbyte = r_k_buf[w_kidx[ADDR_W-1:0]];
    assign w_ibyte = r_in_buf[w_iidx[ADDR_W-1:0]];
    assign w_kval  = {{(INT32_SIZE-8){w_kbyte[7]}}, w_kbyte};
    assign w_ival  = {{(INT32_SIZE-8){w_ibyte[7]}}, w_ibyte} + $signed(r_offset);
    assign w_term[i] = (w_kidx < w_n) ? INT32_SIZE'(w_kval * w_ival) : '0;
  end

  always_comb begin
    w_lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      w_lane_sum = w_lane_sum + w_term[i];
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_in) r_in_buf[inp0[ADDR_W-1:0]] <= inp1[7:0];
    if (w_wr_k)  r_k_buf[inp0[ADDR_W-1:0]]  <= inp1[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (en) begin
      case (r_state)
        ST_IDLE:  if (w_start) w_state_nxt = ST_RUN;
        ST_RUN: begin
          if (w_abort)                     w_state_nxt = ST_IDLE;
          else if (r_step == w_last_step) w_state_nxt = ST_DRAIN;
        end
        ST_DRAIN: w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ret        <= '0;
      r_offset   <= '0;
      r_bias     <= '0;
      r_depth    <= '0;
      r_start_x  <= '0;
      r_acc      <= '0;
      r_cycles   <= '0;
      r_err      <= 1'b0;
      r_aborted  <= 1'b0;
      r_done     <= 1'b1;
      r_step     <= '0;
      r_iss_vld  <= 1'b0;
      r_iss_step <= '0;
      r_s1_vld   <= 1'b0;
      r_s1_sum   <= '0;
    end else if (en) begin
      case (cmd)
        CMD_SIZE:   ret <= INT32_SIZE'(BUFFERS_SIZE);
        CMD_RD_ACC: ret <= r_acc;
        CMD_STATUS: ret <= {{(INT32_SIZE-3){1'b0}}, r_err, r_aborted, r_done};
        CMD_CYCLES: ret <= r_cycles;
        default:    ret <= '0;
      endcase

      if (!w_busy) begin
        case (cmd)
          CMD_OFFSET:  r_offset  <= inp1;
          CMD_BIAS:    r_bias    <= inp1;
          CMD_DEPTH:   if (w_depth_ok) r_depth <= DEPTH_W'(inp1);
                       else            r_err   <= 1'b1;
          CMD_START_X: r_start_x <= IDX_W'(inp1 % INT32_SIZE'(KERNEL_LENGTH));
          default: ;
        endcase
      end
      if (w_cfg_cmd && w_busy) r_err <= 1'b1;
      if (((cmd == CMD_WR_IN) || (cmd == CMD_WR_K)) && !w_addr_ok) r_err <= 1'b1;

      // Issue -> stage1 (lane sum) -> stage2 (accumulate); abort flushes both.
      r_iss_vld <= (r_state == ST_RUN) && !w_abort;
      if (r_state == ST_RUN) begin
        r_iss_step <= r_step;
        r_step     <= r_step + IDX_W'(1);
      end
      r_s1_vld <= r_iss_vld && !w_abort;
      r_s1_sum <= w_lane_sum;
      if (r_s1_vld && !w_abort) r_acc <= r_acc + r_s1_sum;
      if (w_busy) r_cycles <= r_cycles + INT32_SIZE'(1);

      if (w_abort) begin
        r_done    <= 1'b1;
        r_aborted <= 1'b1;
      end else if (r_state == ST_DRAIN) begin
        // Raised one cycle ahead of the final add so a poll at T+S+2 sees it.
        r_done <= 1'b1;
      end

      if (w_start) begin
        r_acc     <= r_bias;
        r_done    <= 1'b0;
        r_aborted <= 1'b0;
        r_err     <= 1'b0;
        r_step    <= '0;
        r_cycles  <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv1d_mac_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv1d_mac_engine
// Purpose  : Scoreboard bench for conv1d_mac_engine. Each command pushes an
//            entry (expected ret or don't-care); a monitor pops one entry per
//            enabled clock edge and compares ret just after the edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv1d_mac_engine;

  localparam int KL = 8;
  localparam int MIC = 128;
  localparam int LN = 16;
  localparam int BS = KL * MIC;

  logic        clk = 1'b0;
  logic        reset, en;
  logic [6:0]  cmd;
  logic [31:0] inp0, inp1;
  logic [31:0] ret;
  logic        obv;

  conv1d_mac_engine #(
    .KERNEL_LENGTH(KL), .MAX_INPUT_CHANNELS(MIC), .LANES(LN), .INT32_SIZE(32)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .cmd(cmd), .inp0(inp0), .inp1(inp1),
    .ret(ret), .output_buffer_valid(obv)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    logic [31:0] exp;
    string       tag;
  } sb_t;

  sb_t sb_q[$];
  sb_t mon_e;
  int  n_vec = 0;
  int  n_err = 0;

  logic [7:0]  m_in [BS];
  logic [7:0]  m_k  [BS];
  int          m_depth, m_sx;
  logic [31:0] m_off, m_bias;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    if (en === 1'b1 && reset === 1'b0) begin
      #1;
      if (sb_q.size() == 0) chk("sb_underflow", 32'(sb_q.size()), 32'd1);
      else begin
        mon_e = sb_q.pop_front();
        if (mon_e.chk) chk(mon_e.tag, ret, mon_e.exp);
      end
    end
  end

  task automatic issue(input logic [6:0] c, input logic [31:0] a, input logic [31:0] b,
                       input bit ck, input logic [31:0] ex, input string tag);
    @(negedge clk);
    reset = 1'b0; en = 1'b1; cmd = c; inp0 = a; inp1 = b;
    sb_q.push_back('{ck, ex, tag});
  endtask

  task automatic wr(input logic [6:0] c, input logic [31:0] a, input logic [31:0] b);
    issue(c, a, b, 1'b0, 32'd0, "wr");
  endtask

  task automatic nop();
    issue(7'd15, 32'd0, 32'd0, 1'b0, 32'd0, "nop");
  endtask

  task automatic rd(input logic [6:0] c, input logic [31:0] ex, input string tag);
    issue(c, 32'd0, 32'd0, 1'b1, ex, tag);
  endtask

  task automatic pause(input int n);
    repeat (n) begin
      @(negedge clk);
      en = 1'b0; cmd = 7'd15;
    end
  endtask

  task automatic set_in(input int a, input logic [7:0] v);
    m_in[a] = v; wr(7'd1, 32'(a), {24'd0, v});
  endtask

  task automatic set_k(input int a, input logic [7:0] v);
    m_k[a] = v; wr(7'd2, 32'(a), {24'd0, v});
  endtask

  task automatic cfg(input int d, input logic [31:0] off, input logic [31:0] bias, input int sx);
    m_depth = d; m_off = off; m_bias = bias; m_sx = sx % KL;
    wr(7'd5, 32'd0, 32'(d));
    wr(7'd3, 32'd0, off);
    wr(7'd4, 32'd0, bias);
    wr(7'd8, 32'd0, 32'(sx));
  endtask

  // Direct convolution reference: bias + sum k[j] * (in[(base+j) mod N] + offset).
  function automatic logic [31:0] model();
    int n, base, iidx;
    logic signed [31:0] acc, kv, iv;
    n = KL * m_depth;
    base = m_sx * m_depth;
    acc = m_bias;
    for (int j = 0; j < n; j++) begin
      iidx = (base + j) % n;
      kv = {{24{m_k[j][7]}}, m_k[j]};
      iv = {{24{m_in[iidx][7]}}, m_in[iidx]} + m_off;
      acc = acc + kv * iv;
    end
    return acc;
  endfunction

  function automatic int steps();
    return (KL * m_depth + LN - 1) / LN;
  endfunction

  task automatic run_job(input string tag);
    int s;
    s = steps();
    wr(7'd6, 32'd0, 32'd0);
    repeat (s) nop();
    rd(7'd9, 32'd0, {tag, "_busy"});
    rd(7'd9, 32'd1, {tag, "_done"});
    rd(7'd7, model(), {tag, "_acc"});
    rd(7'd11, 32'(s + 2), {tag, "_cycles"});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; en = 1'b0; cmd = 7'd0; inp0 = '0; inp1 = '0;
    for (int i = 0; i < BS; i++) begin m_in[i] = '0; m_k[i] = '0; end
    repeat (3) @(negedge clk);

    // Reset state and simple responses
    rd(7'd7, 32'd0, "rst_acc");
    rd(7'd9, 32'd1, "rst_status");
    rd(7'd11, 32'd0, "rst_cycles");
    rd(7'd0, 32'(BS), "bufsize");
    rd(7'd12, 32'd0, "unknown_cmd");
    chk("obuf_valid", {31'd0, obv}, 32'd1);

    // Basic job: k = in = 1..8
    for (int i = 0; i < 8; i++) begin
      set_k(i, 8'(i + 1));
      set_in(i, 8'(i + 1));
    end
    cfg(1, 32'd0, 32'd0, 0);
    run_job("t1");
    rd(7'd7, 32'd204, "t1_const");

    // Offset cancels -128 inputs; then two inputs at 1 via the ring wrap
    cfg(2, 32'd128, 32'hFFFF_FFFB, 3);
    for (int i = 0; i < 16; i++) begin
      set_k(i, 8'd1);
      set_in(i, 8'h80);
    end
    run_job("t2");
    rd(7'd7, 32'hFFFF_FFFB, "t2_const");
    set_in(6, 8'd1);
    set_in(7, 8'd1);
    run_job("t2wrap");
    rd(7'd7, 32'd253, "t2wrap_const");

    // depth 3: partial last chunk, random data
    cfg(3, $urandom_range(0, 255) - 32'd100, $urandom(), $urandom_range(0, 7));
    for (int i = 0; i < 24; i++) begin
      set_k(i, 8'($urandom()));
      set_in(i, 8'($urandom()));
    end
    run_job("t3");

    // Busy writes and restart are ignored; write sets err
    wr(7'd6, 32'd0, 32'd0);
    wr(7'd1, 32'd0, 32'h55);
    wr(7'd6, 32'd0, 32'd0);
    rd(7'd9, 32'd4, "busy_err_running");
    rd(7'd9, 32'd5, "busy_err_done");
    rd(7'd7, model(), "busy_acc");
    rd(7'd11, 32'd4, "busy_cycles");

    // Abort mid-run: accumulator keeps bias (no adds yet)
    wr(7'd6, 32'd0, 32'd0);
    wr(7'd10, 32'd0, 32'd0);
    rd(7'd9, 32'd3, "abort_status");
    rd(7'd7, m_bias, "abort_acc");
    wr(7'd10, 32'd0, 32'd0);
    rd(7'd9, 32'd3, "abort_idle_status");

    // Reset during a run, then rerun the same job
    wr(7'd6, 32'd0, 32'd0);
    nop();
    @(negedge clk);
    reset = 1'b1; en = 1'b1; cmd = 7'd15;
    rd(7'd9, 32'd1, "rst_run_status");
    rd(7'd7, 32'd0, "rst_run_acc");
    cfg(m_depth, m_off, m_bias, m_sx);
    run_job("rerun");

    // en low for 5 cycles mid-run must not change result or cycle count
    wr(7'd6, 32'd0, 32'd0);
    nop();
    pause(5);
    repeat (steps() - 1) nop();
    rd(7'd9, 32'd0, "en_busy");
    rd(7'd9, 32'd1, "en_done");
    rd(7'd7, model(), "en_acc");
    rd(7'd11, 32'(steps() + 2), "en_cycles");

    // Illegal depth rejected and old depth kept; out-of-range write flags err
    wr(7'd5, 32'd0, 32'd200);
    rd(7'd9, 32'd5, "depth200_err");
    run_job("depth_kept");
    wr(7'd1, 32'(BS), 32'd7);
    rd(7'd9, 32'd5, "oob_err");

    @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
